// File: rtl/sobel_window.sv
// sobel_window: buffers two video lines and presents a zero-padded 3x3 luma window per pixel.
// Latency: 2 clk from luma_i/dv_i/hs_i/vs_i to win_o/dv_o/hs_o/vs_o; overflow_o is registered 1 clk after the offending pixel.
// Backpressure: none, a pixel is accepted on every dv_i=1 cycle and the window holds while the stage-1 dv is 0.
module sobel_window #(
  parameter int COLORDEPTH = 8,
  parameter int MAX_LINE   = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COLORDEPTH-1:0]   luma_i,
  input  logic                    dv_i,
  input  logic                    hs_i,
  input  logic                    vs_i,
  output logic [9*COLORDEPTH-1:0] win_o,
  output logic                    dv_o,
  output logic                    hs_o,
  output logic                    vs_o,
  output logic                    overflow_o
);

  localparam int CD = COLORDEPTH;
  // Address width of a line buffer.
  localparam int AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  // The column count runs one past the last address so that an overflowing pixel can be told apart
  // from a legitimate pixel at address MAX_LINE-1.
  localparam int CW = $clog2(MAX_LINE + 1);

  // Input-side line tracking.
  logic          dv_prev;
  logic          vs_prev;
  logic [CW-1:0] col_q;
  logic [1:0]    row_q;
  logic          overflow_q;
  logic          col_sat;
  logic [AW-1:0] addr;
  logic          frame_start;
  logic          line_end;

  // Line buffers: lb0 holds row r-1, lb1 holds row r-2; no reset on the contents.
  logic [CD-1:0] lb0_mem [MAX_LINE];
  logic [CD-1:0] lb1_mem [MAX_LINE];
  logic [CD-1:0] lb0_rd;
  logic [CD-1:0] lb1_raw;

  // lb1 is written one cycle late with the registered lb0 read data, so a back-to-back access
  // to the same address (only possible at column saturation) must be forwarded.
  logic          wr1_en;
  logic [AW-1:0] wr1_addr;
  logic          fwd_hit;
  logic [CD-1:0] fwd_dat;
  logic [CD-1:0] lb1_s;

  // Stage 1.
  logic          dv1;
  logic          hs1;
  logic          vs1;
  logic [CD-1:0] luma1;
  logic [AW-1:0] col1;
  logic [1:0]    row1;

  // Stage 2.
  logic [9*CD-1:0] win_q;
  logic [9*CD-1:0] win_nxt;
  logic            dv2;
  logic            hs2;
  logic            vs2;

  logic [CD-1:0] cur      [9];
  logic [CD-1:0] nxt      [9];
  logic [CD-1:0] incoming [3];

  assign col_sat     = (col_q == CW'(MAX_LINE));
  assign addr        = col_sat ? AW'(MAX_LINE - 1) : col_q[AW-1:0];
  assign frame_start = vs_i & ~vs_prev;
  assign line_end    = dv_prev & ~dv_i;

  // Column/row counters, edge detectors and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      dv_prev <= dv_i;
      vs_prev <= vs_i;
      if (dv_i) begin
        if (!col_sat) begin
          col_q <= col_q + CW'(1);
        end
      end else begin
        col_q <= '0;
      end
      // A frame start takes priority over a coincident line end.
      if (frame_start) begin
        row_q <= '0;
      end else if (line_end && (row_q != 2'd2)) begin
        row_q <= row_q + 2'd1;
      end
      if (frame_start) begin
        overflow_q <= 1'b0;
      end else if (dv_i && col_sat) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // lb0: read-first port, the incoming pixel replaces the previous line's pixel.
  always_ff @(posedge clk) begin
    if (dv_i) begin
      lb0_rd        <= lb0_mem[addr];
      lb0_mem[addr] <= luma_i;
    end
  end

  // lb1: read at the current column, written one cycle later with the pixel lb0 just gave up.
  always_ff @(posedge clk) begin
    if (dv_i) begin
      lb1_raw <= lb1_mem[addr];
    end
    if (wr1_en) begin
      lb1_mem[wr1_addr] <= lb0_rd;
    end
  end

  assign lb1_s = fwd_hit ? fwd_dat : lb1_raw;

  // Stage 1: delayed lb1 write control, forwarding, and the pixel/position/sync registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr1_en   <= 1'b0;
      wr1_addr <= '0;
      fwd_hit  <= 1'b0;
      fwd_dat  <= '0;
      dv1      <= 1'b0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      luma1    <= '0;
      col1     <= '0;
      row1     <= '0;
    end else begin
      wr1_en   <= dv_i;
      wr1_addr <= addr;
      fwd_hit  <= dv_i & wr1_en & (addr == wr1_addr);
      fwd_dat  <= lb0_rd;
      dv1      <= dv_i;
      hs1      <= hs_i;
      vs1      <= vs_i;
      luma1    <= luma_i;
      col1     <= addr;
      row1     <= row_q;
    end
  end

  // Next window: shift one column left, append the new column, then zero the padded taps.
  always_comb begin
    win_nxt     = '0;
    incoming[0] = lb1_s;
    incoming[1] = lb0_rd;
    incoming[2] = luma1;
    for (int i = 0; i < 9; i++) begin
      cur[i] = win_q[(8-i)*CD +: CD];
    end
    for (int r = 0; r < 3; r++) begin
      nxt[r*3]     = cur[r*3+1];
      nxt[r*3 + 1] = cur[r*3+2];
      nxt[r*3 + 2] = incoming[r];
    end
    // Rows above the frame's first lines are padding, which also hides stale buffer contents.
    if (row1 != 2'd2) begin
      nxt[0] = '0;
      nxt[1] = '0;
      nxt[2] = '0;
    end
    if (row1 == 2'd0) begin
      nxt[3] = '0;
      nxt[4] = '0;
      nxt[5] = '0;
    end
    // Columns left of the line start are padding.
    if (col1 == '0) begin
      nxt[1] = '0;
      nxt[4] = '0;
      nxt[7] = '0;
    end
    if (col1 <= AW'(1)) begin
      nxt[0] = '0;
      nxt[3] = '0;
      nxt[6] = '0;
    end
    for (int i = 0; i < 9; i++) begin
      win_nxt[(8-i)*CD +: CD] = nxt[i];
    end
  end

  // Stage 2: window advances only on valid stage-1 pixels; syncs always advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_q <= '0;
      dv2   <= 1'b0;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
    end else begin
      dv2 <= dv1;
      hs2 <= hs1;
      vs2 <= vs1;
      if (dv1) begin
        win_q <= win_nxt;
      end
    end
  end

  assign win_o      = win_q;
  assign dv_o       = dv2;
  assign hs_o       = hs2;
  assign vs_o       = vs2;
  assign overflow_o = overflow_q;

endmodule
